// File: rtl/key_schedule_seq.sv
// Sequential AES key-schedule generator (NK = 4/6/8), one schedule word per clock,
// round keys out over valid/ready. Optional abort input: define KEYSCHED_ABORT_EN.
module key_schedule_seq #(
    parameter int NK    = 4,
    parameter int WORD  = 32,
    parameter int KEY_W = NK * WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
`ifdef KEYSCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_index,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start, outputs quiet
    // GEN   | producing one schedule word per unstalled cycle
    // FLUSH | all words produced, waiting for the last round key to be taken
    typedef enum logic [1:0] {IDLE, GEN, FLUSH} state_t;

    if (!(NK == 4 || NK == 6 || NK == 8) || WORD != 32) begin : g_bad_param
        $error("key_schedule_seq: NK must be 4, 6 or 8 and WORD must be 32");
    end

    localparam int         NR     = NK + 6;
    localparam logic [5:0] LAST_I = 6'(4 * (NR + 1) - 1);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] rc;
        case (n)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t          state;
    logic [WORD-1:0] win [NK];
    logic [95:0]     stage;
    logic [5:0]      i;
    logic [2:0]      pos;
    logic [3:0]      rnd;
    logic [WORD-1:0] new_word;
    logic            stall;
    logic            xfer;

    // win[0] is w[i-NK], win[NK-1] is w[i-1]. During the first NK words the
    // window simply rotates, which replays the key and restores its order.
    always_comb begin
        new_word = win[0];
        if (rnd != 4'd0) begin
            if (pos == 3'd0)
                new_word = win[0] ^ sub_word(rot_word(win[NK-1])) ^ {rcon(rnd), 24'h0};
            else if (NK == 8 && pos == 3'd4)
                new_word = win[0] ^ sub_word(win[NK-1]);
            else
                new_word = win[0] ^ win[NK-1];
        end
    end

    assign stall = (i[1:0] == 2'd3) && rk_valid && !rk_ready;
    assign xfer  = rk_valid && rk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            for (int j = 0; j < NK; j++) win[j] <= '0;
            stage    <= '0;
            i        <= '0;
            pos      <= '0;
            rnd      <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int j = 0; j < NK; j++)
                            win[j] <= key_in[KEY_W-1-WORD*j -: WORD];
                        i     <= '0;
                        pos   <= '0;
                        rnd   <= '0;
                        busy  <= 1'b1;
                        state <= GEN;
                    end
                end
                GEN: begin
                    if (!stall) begin
                        for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
                        win[NK-1] <= new_word;
                        stage     <= {stage[63:0], new_word};
                        i         <= i + 6'd1;
                        if (pos == 3'(NK - 1)) begin
                            pos <= '0;
                            rnd <= rnd + 4'd1;
                        end else begin
                            pos <= pos + 3'd1;
                        end
                        if (i[1:0] == 2'd3) begin
                            rk_data  <= {stage, new_word};
                            rk_index <= i[5:2];
                            rk_valid <= 1'b1;
                        end else if (xfer) begin
                            rk_valid <= 1'b0;
                        end
                        if (i == LAST_I) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (xfer) begin
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef KEYSCHED_ABORT_EN
            // Placed last so it overrides any same-edge transfer or completion.
            if (abort && state != IDLE) begin
                state    <= IDLE;
                rk_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
                stage    <= '0;
            end
`endif
        end
    end

endmodule
